shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide parameter EARLY_EXIT, default 0. When 1, the block finishes as soon as no further stage would change the data.
REQ-003 clock  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 data_in  input  32  operand; captured when start is accepted.
REQ-007 shamt  input  5  shift amount 0..31; captured when start is accepted.
REQ-008 shift_type  input  2  operation, captured when start is accepted: 00 sll, 01 srl, 10 sra, 11 reserved.
REQ-009 busy  output  1  high while in state SHIFT.
REQ-010 done  output  1  one-cycle pulse; high in state DONE.
REQ-011 result  output  32  shifted value; valid when done=1; held until the next accepted start.

Function
REQ-012 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-013 IDLE, start=1: the rising edge captures data_in into the working register, and captures shamt and shift_type.
- The stage index is loaded with 4, selecting a 16-bit stage.
- The next state is SHIFT.
REQ-014 IDLE, start=0: the block SHALL hold state, working register and result.
REQ-015 SHIFT: each rising edge processes one stage, in the order 16, 8, 4, 2, 1 (stage index 4 down to 0).
- If captured shamt bit[index] is set, the shift is applied to the working register.
- If the bit is clear, the working register is unchanged.
REQ-016 Stage operation for each captured shift_type:
- sll: shift left, zero fill.
- srl: shift right, zero fill.
- sra: shift right, filling with the current working-register bit 31. This equals the original sign bit.
REQ-017 shift_type 11 SHALL leave the working register unchanged in every stage. result then equals data_in.
REQ-018 SHIFT to DONE transition:
- EARLY_EXIT=0: on the edge that processes stage index 0.
- EARLY_EXIT=1: on the edge that processes the highest stage index such that every remaining lower shamt bit is zero.
REQ-019 EARLY_EXIT=1 with captured shamt=0 SHALL take exactly one SHIFT cycle.
REQ-020 On entry to DONE, result SHALL be loaded from the final working-register value.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-022 Latency with EARLY_EXIT=0: start accepted at edge E.
- busy=1 for the 5 cycles after E.
- done=1 in the cycle after edge E+5.
- A new start is accepted no earlier than edge E+7.
REQ-023 start SHALL be ignored in SHIFT and in DONE. Inputs sampled in those states have no effect.
REQ-024 After reset release, the first accepted operation SHALL not depend on any operation aborted by reset.
REQ-025 busy and done SHALL never be high together.

Reset
REQ-026 While reset=0, the block SHALL immediately and asynchronously force:
- state to IDLE;
- busy=0 and done=0;
- result=32'h0;
- the working register, captured shamt, captured shift_type and stage index to 0.
REQ-027 An assertion of reset during SHIFT or DONE SHALL abort the operation with no done pulse.
REQ-028 The first rising edge after reset deasserts SHALL treat start as in IDLE.

Verification
REQ-029 sll, EARLY_EXIT=0:
- Stimulus: data_in=32'h0000_0001, shamt=31, shift_type=00.
- Response: busy high 5 cycles, then done=1 with result=32'h8000_0000.
REQ-030 sra:
- Stimulus: data_in=32'h8000_0F00, shamt=8, shift_type=10.
- Response: result=32'hFF80_000F after 5 SHIFT cycles.
REQ-031 srl with a held start:
- Stimulus: data_in=32'hF000_0000, shamt=4, shift_type=01; start held high through the whole operation.
- Response: result=32'h0F00_0000; exactly one done pulse per accepted start; restart at edge E+7.
REQ-032 EARLY_EXIT=1:
- Stimulus: shamt=16, sll, data_in=32'h0000_FFFF.
- Response: one SHIFT cycle, then done with result=32'hFFFF_0000.
- Stimulus: shamt=0.
- Response: one SHIFT cycle, result=data_in.
REQ-033 Reset mid-operation:
- Stimulus: reset=0 for one cycle during the third SHIFT cycle.
- Response: busy=0 and result=0 immediately, no done pulse; the next operation produces a correct result.
REQ-034 Reserved type:
- Stimulus: shift_type=11, data_in=32'hA5A5_5A5A, shamt=7.
- Response: result=32'hA5A5_5A5A after 5 SHIFT cycles.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies one power-of-two stage per clock (16, 8, 4, 2, 1).
// With EARLY_EXIT set, it finishes once every remaining shamt bit is zero.
module shift_sequencer #(
  parameter int EARLY_EXIT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  input  logic [1:0]  shift_type,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [31:0] work;
  logic [31:0] stage_work;
  logic [4:0]  amt;
  logic [4:0]  stage_amt;
  logic [4:0]  low_mask;
  logic [1:0]  typ;
  logic [2:0]  idx;
  logic        last_stage;

  // stage_amt is the one-hot weight of the current stage; low_mask covers the stages still to come
  assign stage_amt  = 5'd1 << idx;
  assign low_mask   = stage_amt - 5'd1;
  assign last_stage = (idx == 3'd0) || ((EARLY_EXIT != 0) && ((amt & low_mask) == 5'd0));

  always_comb begin
    stage_work = work;
    if ((amt & stage_amt) != 5'd0) begin
      case (typ)
        2'b00:   stage_work = work << stage_amt;
        2'b01:   stage_work = work >> stage_amt;
        2'b10:   stage_work = $unsigned($signed(work) >>> stage_amt);
        default: stage_work = work;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'h0;
      work   <= 32'h0;
      amt    <= 5'd0;
      typ    <= 2'd0;
      idx    <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= data_in;
            amt   <= shamt;
            typ   <= shift_type;
            idx   <= 3'd4;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= stage_work;
          if (last_stage) begin
            result <= stage_work;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: runs EARLY_EXIT=0 and EARLY_EXIT=1 instances side by side
// against an arithmetic reference model with directed and random operations.
module tb_shift_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  shift_type;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [31:0] result_v [2];

  int n_cmp;
  int n_err;
  int busy_n [2];
  int done_n [2];
  int done_at [2];
  logic [31:0] res_at [2];

  shift_sequencer #(.EARLY_EXIT(0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .shamt(shamt), .shift_type(shift_type),
    .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0])
  );

  shift_sequencer #(.EARLY_EXIT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .data_in(data_in),
    .shamt(shamt), .shift_type(shift_type),
    .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference result straight from the operation definitions
  function automatic logic [31:0] model_result(input logic [31:0] d, input logic [4:0] sh,
                                               input logic [1:0] ty);
    logic [31:0] r;
    case (ty)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = $unsigned($signed(d) >>> sh);
      default: r = d;
    endcase
    return r;
  endfunction

  // Number of SHIFT cycles: five, or with early exit down to the lowest set shamt bit
  function automatic int model_cycles(input int ee, input logic [4:0] sh);
    if (ee == 0) return 5;
    if (sh == 5'd0) return 1;
    for (int i = 0; i < 5; i++)
      if (sh[i]) return 5 - i;
    return 5;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      busy_n[i]  = 0;
      done_n[i]  = 0;
      done_at[i] = -1;
      res_at[i]  = 32'h0;
    end
  endtask

  task automatic sample(input int k);
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("busy_done_excl[%0d]", i), {31'h0, busy_v[i] & done_v[i]}, 32'h0);
      if (busy_v[i]) busy_n[i]++;
      if (done_v[i]) begin
        done_n[i]++;
        done_at[i] = k;
        res_at[i]  = result_v[i];
      end
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] ty);
    logic [31:0] exp_r;
    int exp_c;
    exp_r = model_result(d, sh, ty);
    clear_stats();
    @(negedge clock);
    data_in = d; shamt = sh; shift_type = ty; start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 1) begin
        @(negedge clock);
        start = 1'b0;
        data_in = $urandom; shamt = 5'($urandom); shift_type = 2'($urandom);
      end
      @(posedge clock); #1;
      sample(k);
    end
    for (int i = 0; i < 2; i++) begin
      exp_c = model_cycles(i, sh);
      check_output($sformatf("busy_cycles[%0d] %h/%0d/%0d", i, d, sh, ty), busy_n[i], exp_c);
      check_output($sformatf("done_pulses[%0d] %h/%0d/%0d", i, d, sh, ty), done_n[i], 1);
      check_output($sformatf("done_time[%0d] %h/%0d/%0d", i, d, sh, ty), done_at[i], exp_c);
      check_output($sformatf("result[%0d] %h/%0d/%0d", i, d, sh, ty), res_at[i], exp_r);
      check_output($sformatf("result_hold[%0d] %h/%0d/%0d", i, d, sh, ty), result_v[i], exp_r);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    start = 1'b0;
    data_in = 32'h0;
    shamt = 5'd0;
    shift_type = 2'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("reset_busy[%0d]", i), {31'h0, busy_v[i]}, 32'h0);
      check_output($sformatf("reset_done[%0d]", i), {31'h0, done_v[i]}, 32'h0);
      check_output($sformatf("reset_result[%0d]", i), result_v[i], 32'h0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;

    $display("[TB] directed operations");
    apply_stimulus(32'h0000_0001, 5'd31, 2'b00);
    apply_stimulus(32'h8000_0F00, 5'd8,  2'b10);
    apply_stimulus(32'hA5A5_5A5A, 5'd7,  2'b11);
    apply_stimulus(32'h0000_FFFF, 5'd16, 2'b00);
    apply_stimulus(32'h1234_5678, 5'd0,  2'b01);
    apply_stimulus(32'h8765_4321, 5'd0,  2'b10);
    check_output("spec_sll31", model_result(32'h0000_0001, 5'd31, 2'b00), 32'h8000_0000);
    check_output("spec_sra8", model_result(32'h8000_0F00, 5'd8, 2'b10), 32'hFF80_000F);

    $display("[TB] held start");
    clear_stats();
    @(negedge clock);
    data_in = 32'hF000_0000; shamt = 5'd4; shift_type = 2'b01; start = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      @(posedge clock); #1;
      sample(k);
      if (k == 6) check_output("held_idle_gap", {31'h0, busy_v[0]}, 32'h0);
      if (k == 7) check_output("held_restart", {31'h0, busy_v[0]}, 32'h1);
    end
    @(negedge clock);
    start = 1'b0;
    check_output("held_dones[0]", done_n[0], 2);
    check_output("held_dones[1]", done_n[1], 3);
    check_output("held_result[0]", res_at[0], 32'h0F00_0000);
    check_output("held_result[1]", res_at[1], 32'h0F00_0000);
    repeat (10) @(negedge clock);

    $display("[TB] reset mid-operation");
    clear_stats();
    @(negedge clock);
    data_in = 32'hDEAD_BEEF; shamt = 5'd13; shift_type = 2'b00; start = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output($sformatf("abort_busy[%0d]", i), {31'h0, busy_v[i]}, 32'h0);
      check_output($sformatf("abort_done[%0d]", i), {31'h0, done_v[i]}, 32'h0);
      check_output($sformatf("abort_result[%0d]", i), result_v[i], 32'h0);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      sample(k);
    end
    check_output("abort_no_done[0]", done_n[0], 0);
    check_output("abort_no_done[1]", done_n[1], 0);
    apply_stimulus(32'h8000_0F00, 5'd8, 2'b10);

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++)
      apply_stimulus($urandom, 5'($urandom), 2'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
